// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command front-end for the memory-mapped ALU block. Takes one request per
//   valid/ready handshake, programs A, B, OPERATION and EXECUTE over the bus,
//   waits for the ALU's registered result, samples it, clears EXECUTE and then
//   presents result plus status until the consumer takes it.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_a, req_b, req_op payload
//   resp_valid/resp_ready response handshake; resp_result, resp_err, resp_dz
//   enable, rd_wr, addr,  bus master side towards the ALU register map
//   wr_data
//   res_out               ALU registered result
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 2,
  parameter int RES_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_WIDTH-1:0]   req_a,
  input  logic [DATA_WIDTH-1:0]   req_b,
  input  logic [2:0]              req_op,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [2*DATA_WIDTH-1:0] resp_result,
  output logic                    resp_err,
  output logic                    resp_dz,
  output logic                    enable,
  output logic                    rd_wr,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [2*DATA_WIDTH-1:0] res_out
);

  localparam int CNT_W = (RES_LATENCY > 2) ? $clog2(RES_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, WR_OP, WR_EXEC, WAIT, CLR_EXEC, RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    err_q, err_d;
  logic                    dz_q, dz_d;

  // Latched request payload; no reset needed, only read after a handshake.
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [2:0]              op_q;
  logic                    accept;

  assign accept = (state_q == IDLE) && req_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      dz_q    <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= req_a;
      b_q  <= req_b;
      op_q <= req_op;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE:     if (req_valid) state_d = WR_A;
      WR_A:     state_d = WR_B;
      WR_B:     state_d = WR_OP;
      WR_OP:    state_d = WR_EXEC;
      WR_EXEC: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(RES_LATENCY - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // Leaving edge is RES_LATENCY edges after the EXEC write committed.
          state_d = CLR_EXEC;
          res_d   = res_out;
          err_d   = (op_q > 3'd4);
          dz_d    = (op_q == 3'd4) && (b_q == '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CLR_EXEC: state_d = RESP;
      RESP:     if (resp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode; bus defaults to the idle encoding
  always_comb begin
    enable  = 1'b0;
    rd_wr   = 1'b1;
    addr    = '0;
    wr_data = '0;
    case (state_q)
      WR_A: begin
        enable = 1'b1; rd_wr = 1'b0; addr = ADDR_WIDTH'(0); wr_data = a_q;
      end
      WR_B: begin
        enable = 1'b1; rd_wr = 1'b0; addr = ADDR_WIDTH'(1); wr_data = b_q;
      end
      WR_OP: begin
        enable = 1'b1; rd_wr = 1'b0; addr = ADDR_WIDTH'(2); wr_data = DATA_WIDTH'(op_q);
      end
      WR_EXEC: begin
        enable = 1'b1; rd_wr = 1'b0; addr = ADDR_WIDTH'(3); wr_data = DATA_WIDTH'(1);
      end
      CLR_EXEC: begin
        enable = 1'b1; rd_wr = 1'b0; addr = ADDR_WIDTH'(3); wr_data = '0;
      end
      default: ;
    endcase
  end

  // State decodes IDLE during reset, so ready is gated by rst_n explicitly.
  assign req_ready   = (state_q == IDLE) && rst_n;
  assign resp_valid  = (state_q == RESP);
  assign resp_result = res_q;
  assign resp_err    = err_q;
  assign resp_dz     = dz_q;

endmodule
